// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: shadow EX/MEM/WB destination records drive operand forward selects,
// load-use stall and a saturating stall counter. Optional retired-stage bypass: FWD_RETIRE_BYPASS_EN.
module forwarding_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int N_READ     = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [N_READ*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0]        id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_is_load,
  output logic [N_READ*2-1:0]          fwd_sel,
  output logic                         stall,
  output logic [CNT_W-1:0]             stall_count
);

  localparam int AW = REG_ADDR_W;

  logic                   r_ex_vld, r_mem_vld, r_wb_vld;
  logic [AW-1:0]          r_ex_rd, r_mem_rd, r_wb_rd;
  logic                   r_ex_rw, r_mem_rw, r_wb_rw;
  logic                   r_ex_ld;
  logic [N_READ*AW-1:0]   r_ex_rs;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_ex_live, w_mem_live, w_wb_live;
  logic                   w_ex_rs_hit, w_stall, w_issue;
  logic [AW-1:0]          w_rs;
  logic [N_READ*2-1:0]    w_fwd;

`ifdef FWD_RETIRE_BYPASS_EN
  logic                   r_ret_vld;
  logic [AW-1:0]          r_ret_rd;
  logic                   r_ret_rw;
  logic                   w_ret_live;

  assign w_ret_live = r_ret_vld & r_ret_rw & (r_ret_rd != '0);
`endif

  assign w_ex_live  = r_ex_vld  & r_ex_rw  & (r_ex_rd  != '0);
  assign w_mem_live = r_mem_vld & r_mem_rw & (r_mem_rd != '0);
  assign w_wb_live  = r_wb_vld  & r_wb_rw  & (r_wb_rd  != '0);

  // A load in EX only collides with the ID instruction; later stages are covered by forwarding.
  always_comb begin
    w_ex_rs_hit = 1'b0;
    for (int j = 0; j < N_READ; j++) begin
      if (id_rs_addr[j*AW +: AW] == r_ex_rd) w_ex_rs_hit = 1'b1;
    end
  end

  assign w_stall = id_valid & ~flush & w_ex_live & r_ex_ld & w_ex_rs_hit;
  assign w_issue = id_valid & ~w_stall & ~flush;

  always_comb begin
    w_fwd = '0;
    w_rs  = '0;
    for (int j = 0; j < N_READ; j++) begin
      w_rs = r_ex_rs[j*AW +: AW];
      if (r_ex_vld && (w_rs != '0)) begin
        if (w_mem_live && (r_mem_rd == w_rs))     w_fwd[2*j +: 2] = 2'd1;
        else if (w_wb_live && (r_wb_rd == w_rs))  w_fwd[2*j +: 2] = 2'd2;
`ifdef FWD_RETIRE_BYPASS_EN
        else if (w_ret_live && (r_ret_rd == w_rs)) w_fwd[2*j +: 2] = 2'd3;
`endif
      end
    end
  end

  // Stage boundary: valid bits and counter carry reset, payload does not.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ex_vld  <= 1'b0;
      r_mem_vld <= 1'b0;
      r_wb_vld  <= 1'b0;
`ifdef FWD_RETIRE_BYPASS_EN
      r_ret_vld <= 1'b0;
`endif
      r_cnt     <= '0;
    end else if (en) begin
      r_ex_vld  <= w_issue;
      r_mem_vld <= r_ex_vld;
      r_wb_vld  <= r_mem_vld;
`ifdef FWD_RETIRE_BYPASS_EN
      r_ret_vld <= r_wb_vld;
`endif
      if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      r_ex_rd  <= id_rd;
      r_ex_rw  <= id_reg_write;
      r_ex_ld  <= id_is_load;
      r_ex_rs  <= id_rs_addr;
      r_mem_rd <= r_ex_rd;
      r_mem_rw <= r_ex_rw;
      r_wb_rd  <= r_mem_rd;
      r_wb_rw  <= r_mem_rw;
`ifdef FWD_RETIRE_BYPASS_EN
      r_ret_rd <= r_wb_rd;
      r_ret_rw <= r_wb_rw;
`endif
    end
  end

  assign fwd_sel     = w_fwd;
  assign stall       = w_stall;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench for forwarding_scoreboard: history-queue reference model, directed
// scenarios with literal expectations, then randomized traffic with occasional async resets.
module tb_forwarding_scoreboard;

  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef FWD_RETIRE_BYPASS_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  logic              clk = 1'b0;
  logic              arst_n;
  logic              en, flush, id_valid, id_reg_write, id_is_load;
  logic [NR*AW-1:0]  id_rs_addr;
  logic [AW-1:0]     id_rd;
  logic [NR*2-1:0]   fwd_sel;
  logic              stall;
  logic [CW-1:0]     stall_count;

  int checks   = 0;
  int failures = 0;

  forwarding_scoreboard #(.REG_ADDR_W(AW), .N_READ(NR), .CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: hist[0] is the instruction in EX, hist[k] the one k advances older.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
    bit [4:0] rs0;
    bit [4:0] rs1;
  } rec_t;

  rec_t hist[$];
  int   mcnt;

  function automatic rec_t bubble();
    rec_t r;
    r = '{v: 1'b0, rd: 5'd0, rw: 1'b0, ld: 1'b0, rs0: 5'd0, rs1: 5'd0};
    return r;
  endfunction

  function automatic bit live(rec_t r);
    return r.v && r.rw && (r.rd != 5'd0);
  endfunction

  function automatic bit [1:0] exp_op(bit [4:0] rs);
    if (!hist[0].v || rs == 5'd0) return 2'd0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (live(hist[k]) && hist[k].rd == rs) return 2'(k);
    end
    return 2'd0;
  endfunction

  function automatic bit exp_stall();
    return id_valid && !flush && live(hist[0]) && hist[0].ld &&
           (hist[0].rd == id_rs_addr[4:0] || hist[0].rd == id_rs_addr[9:5]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    mcnt = 0;
    for (int k = 0; k < 4; k++) hist.push_back(bubble());
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) begin
        for (int k = 0; k < 4; k++) hist[k] = bubble();
        mcnt = 0;
      end else if (en) begin
        bit   st;
        rec_t n;
        st = exp_stall();
        if (st && mcnt < CMAX) mcnt++;
        n.v   = id_valid && !st && !flush;
        n.rd  = id_rd;
        n.rw  = id_reg_write;
        n.ld  = id_is_load;
        n.rs0 = id_rs_addr[4:0];
        n.rs1 = id_rs_addr[9:5];
        hist.push_front(n);
        void'(hist.pop_back());
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_fwd",   fwd_sel, {exp_op(hist[0].rs1), exp_op(hist[0].rs0)});
      chk("model_stall", stall, exp_stall());
      chk("model_cnt",   stall_count, mcnt);
    end
  end

  task automatic drive(input bit v, input bit [4:0] r0, input bit [4:0] r1, input bit [4:0] rd,
                       input bit rw, input bit ld, input bit fl, input bit e);
    @(negedge clk);
    #1;
    id_valid = v; id_rs_addr = {r1, r0}; id_rd = rd;
    id_reg_write = rw; id_is_load = ld; flush = fl; en = e;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    arst_n = 1'b0; en = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs_addr = '0; id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fwd", fwd_sel, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_count, 0);
    #2 arst_n = 1'b1;

    // Back-to-back dependency forwards from MEM; one spacer forwards from WB.
    drive(1, 1, 2, 5, 1, 0, 0, 1);
    drive(1, 5, 5, 6, 1, 0, 0, 1);
    nop();
    chk("fwd_mem_both", fwd_sel, 4'b0101);
    drive(1, 3, 4, 9, 1, 0, 0, 1);
    drive(1, 1, 1, 10, 1, 0, 0, 1);
    drive(1, 9, 9, 11, 1, 0, 0, 1);
    nop();
    chk("fwd_wb_both", fwd_sel, 4'b1010);

    // Load-use: one stall, then the re-issued consumer forwards from WB.
    drive(1, 2, 0, 7, 1, 1, 0, 1);
    drive(1, 7, 1, 8, 1, 0, 0, 1);
    chk("lu_stall", stall, 1);
    chk("lu_cnt0", stall_count, 0);
    drive(1, 7, 1, 8, 1, 0, 0, 1);
    chk("lu_stall_once", stall, 0);
    chk("lu_cnt1", stall_count, 1);
    nop();
    chk("lu_fwd", fwd_sel, 4'b0010);

    // Register x0 is never forwarded and never stalls.
    drive(1, 0, 0, 0, 1, 0, 0, 1);
    drive(1, 0, 0, 3, 1, 0, 0, 1);
    chk("x0_stall_a", stall, 0);
    nop();
    chk("x0_fwd_a", fwd_sel, 0);
    drive(1, 0, 0, 0, 1, 1, 0, 1);
    drive(1, 0, 0, 3, 1, 0, 0, 1);
    chk("x0_stall_b", stall, 0);
    nop();
    chk("x0_fwd_b", fwd_sel, 0);

    // Flush overrides stall and kills the ID instruction.
    drive(1, 1, 1, 12, 1, 1, 0, 1);
    drive(1, 12, 12, 13, 1, 0, 1, 1);
    chk("flush_stall", stall, 0);
    nop();
    chk("flush_bubble", fwd_sel, 0);
    chk("flush_cnt", stall_count, 1);

    // Frozen pipeline during a hazard.
    drive(1, 2, 2, 14, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 14, 15, 1, 0, 0, 0);
      chk("frz_stall", stall, 1);
      chk("frz_cnt", stall_count, 1);
    end
    drive(1, 3, 14, 15, 1, 0, 0, 1);
    chk("frz_rel_stall", stall, 1);
    drive(1, 3, 14, 15, 1, 0, 0, 1);
    chk("frz_rel_clear", stall, 0);
    chk("frz_rel_cnt", stall_count, 2);
    nop();
    chk("frz_fwd", fwd_sel, 4'b1000);

    // Counter saturation at 15.
    for (int i = 0; i < 13; i++) begin
      drive(1, 0, 0, 20, 1, 1, 0, 1);
      drive(1, 20, 0, 21, 1, 0, 0, 1);
    end
    nop();
    chk("sat_reach", stall_count, 15);
    drive(1, 0, 0, 20, 1, 1, 0, 1);
    drive(1, 20, 0, 21, 1, 0, 0, 1);
    chk("sat_stall", stall, 1);
    nop();
    chk("sat_hold", stall_count, 15);

    // Producer followed by two independents: retired-stage bypass only with the macro.
    drive(1, 1, 1, 22, 1, 0, 0, 1);
    drive(1, 1, 1, 23, 1, 0, 0, 1);
    drive(1, 1, 1, 24, 1, 0, 0, 1);
    drive(1, 22, 0, 25, 1, 0, 0, 1);
    nop();
`ifdef FWD_RETIRE_BYPASS_EN
    chk("ret_fwd", fwd_sel, 4'b0011);
`else
    chk("ret_fwd", fwd_sel, 4'b0000);
`endif

    // Asynchronous reset mid-hazard, then no stale forwarding.
    drive(1, 1, 1, 26, 1, 1, 0, 1);
    drive(1, 26, 26, 27, 1, 0, 0, 1);
    chk("arst_pre_stall", stall, 1);
    #1 arst_n = 1'b0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_fwd", fwd_sel, 0);
    chk("arst_cnt", stall_count, 0);
    @(negedge clk);
    #3 arst_n = 1'b1;
    drive(1, 26, 26, 28, 1, 0, 0, 1);
    chk("arst_post_stall", stall, 0);
    nop();
    chk("arst_post_fwd", fwd_sel, 0);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 17);
      if ($urandom_range(0, 299) == 0) begin
        #1 arst_n = 1'b0;
        #1;
        chk("rnd_arst_cnt", stall_count, 0);
        chk("rnd_arst_fwd", fwd_sel, 0);
        @(negedge clk);
        #3 arst_n = 1'b1;
      end
    end

    nop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
Parametrised successor to the pipeline forwarding logic. It keeps its own shadow pipeline of destination-register records for the EX, MEM and WB stages, and from that state it drives:
- a multi-bit forward select per EX read operand;
- the load-use stall to IF/ID;
- a saturating stall performance counter.

It sits beside the ID/EX pipeline registers and is fed with the instruction leaving ID. The datapath needs no Rd/RegWrite fan-in from later stages.

Parameters:
- REG_ADDR_W, 5: register address width; address 0 is hard-wired zero and is never forwarded.
- N_READ, 2: number of source operands per instruction.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- en  in  1  pipeline advance; 0 freezes all internal state
- flush  in  1  kill the instruction in ID (branch/jump redirect)
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  N_READ*REG_ADDR_W  source addresses of the ID instruction; operand j is at bits [j*REG_ADDR_W +: REG_ADDR_W]
- id_rd  in  REG_ADDR_W  destination of the ID instruction
- id_reg_write  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load
- fwd_sel  out  N_READ*2  per-operand select for the instruction in EX: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result, 3 = retired-stage result (macro only)
- stall  out  1  hold PC and IF/ID
- stall_count  out  CNT_W  number of stalled advance cycles

Behaviour:
- Reset is asynchronous, active-low, on arst_n. While arst_n=0:
  - EX, MEM and WB entry valid bits = 0;
  - fwd_sel = 0, stall = 0, stall_count = 0.
  - The entry payload fields may be left uninitialised.
  - Reset asserted mid-operation discards all in-flight records immediately, without waiting for a clock edge.
- Entry record: {valid, rd, reg_write, is_load}. The EX entry additionally holds rs[N_READ].
- On a rising edge with en=1:
  - WB <= MEM;
  - MEM <= EX;
  - EX <= ID fields when id_valid & ~stall & ~flush, otherwise a bubble (valid=0).
- On a rising edge with en=0: no state changes and stall_count holds.
- Live entry: valid & reg_write & rd != 0.
- fwd_sel[j] (combinational from registered state):
  - 0 when the EX entry is invalid or rs[j] = 0;
  - otherwise 1 if the MEM entry is live and rd == rs[j];
  - else 2 if the WB entry is live and rd == rs[j];
  - else 0.
  - MEM always has priority over WB when both match (youngest producer wins).
- stall (combinational):
  - asserted when id_valid & ~flush, the EX entry is live with is_load=1, and EX.rd equals any id_rs_addr[j];
  - this rule gives exactly one bubble per load-use pair;
  - a dependency on a load already in MEM or WB never stalls, because that case is covered by forwarding;
  - flush overrides stall: with both conditions present, stall = 0 and a bubble enters EX.
- stall_count:
  - increments by 1 on each rising edge with en & stall;
  - saturates at all-ones and does not wrap.
- Two operands matching different stages resolve independently. Two operands matching the same stage both select that stage.

Optional Feature:
Macro FWD_RETIRE_BYPASS_EN, for register files without write-before-read bypass.
- Defined:
  - a fourth record RET <= WB is added on each en edge, and reset clears its valid bit;
  - fwd_sel = 3 when neither MEM nor WB matches and RET is live with a matching rd;
  - priority is MEM > WB > RET.
- Undefined:
  - no RET storage exists and fwd_sel never takes the value 3.

Test Plan:
1. Reset with arst_n=0 asserted mid-stream, asynchronously and without a clock edge -> fwd_sel=0, stall=0 and stall_count=0 immediately; after release, no stale forwarding appears.
2. Issue add x5 then sub x6,x5,x5 with en=1 every cycle -> when sub is in EX, fwd_sel = {1,1}. Insert one independent instruction between them -> fwd_sel = {2,2}.
3. Issue lw x7 then add x8,x7,x1 -> stall=1 for exactly one cycle and stall_count goes 0 -> 1. The next cycle has add in EX with fwd_sel[0]=2, fwd_sel[1]=0.
4. Issue a write to x0 followed by a read of x0, then a load to x0 followed by a read of x0 -> fwd_sel=0 and stall=0 throughout.
5. Load-use pair with flush=1 in the hazard cycle -> stall=0 and the EX entry becomes a bubble. With en=0 held for 3 cycles during a hazard -> state, stall and stall_count are all frozen.
6. Force stall_count to saturation with CNT_W=4 after 15 stalls, then cause one more stall -> value stays 15. With FWD_RETIRE_BYPASS_EN defined, a producer followed by two independent instructions -> fwd_sel=3.
